// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard.
package reg_scoreboard_pkg;

    // Default register-address width (32 architectural registers).
    localparam int DEFAULT_ADDR_W = 5;

    // Index of the hardwired-zero register.
    localparam int ZERO_REG_IDX = 0;

endpackage

// File: rtl/reg_scoreboard_onehot_decoder.sv
// Binary-to-one-hot decoder with enable; output is all zeros when disabled.
module onehot_decoder
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      in,
    output logic [2**ADDR_W-1:0]   out
);

    // Raise exactly one bit at position 'in' when enabled.
    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per register, gates issue on
// RAW/WAW hazards, and flags writebacks to registers that were not pending.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_rd,
    input  logic [ADDR_W-1:0]      issue_rs1,
    input  logic [ADDR_W-1:0]      issue_rs2,
    output logic                   issue_ready,
    input  logic                   wb_valid,
    input  logic [ADDR_W-1:0]      wb_rd,
    input  logic                   flush,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        busy_count,
    output logic                   err
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);

    logic             rd_is_zero;
    logic             wb_is_zero;
    logic             set_en;
    logic             err_det;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] busy_nxt;

    assign rd_is_zero = ZERO_REG && (issue_rd == ZERO_ADDR);
    assign wb_is_zero = ZERO_REG && (wb_rd == ZERO_ADDR);

    // Hazard check looks only at the registered vector; a same-cycle
    // writeback is deliberately not forwarded.
    assign issue_ready = !(busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]);

    assign set_en  = issue_valid & issue_ready & ~rd_is_zero;
    assign err_det = wb_valid & ~flush & ~busy[wb_rd] & ~wb_is_zero;

    onehot_decoder #(.ADDR_W(ADDR_W)) u_set_dec (
        .en  (set_en),
        .in  (issue_rd),
        .out (set_mask)
    );

    onehot_decoder #(.ADDR_W(ADDR_W)) u_clr_dec (
        .en  (wb_valid),
        .in  (wb_rd),
        .out (clr_mask)
    );

    // Next busy vector: clear then set (set wins on the same register),
    // flush overrides everything, register 0 pinned low when hardwired.
    always_comb begin
        busy_nxt = (busy & ~clr_mask) | set_mask;
        if (flush) begin
            busy_nxt = '0;
        end
        if (ZERO_REG) begin
            busy_nxt[ZERO_REG_IDX] = 1'b0;
        end
    end

    // Busy vector and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            err  <= err | err_det;
        end
    end

    // Population count of the busy vector.
    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_count = busy_count + {{ADDR_W{1'b0}}, busy[i]};
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic against a per-register reference model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    int          checks = 0;
    int          failures = 0;

    // Instance A: ADDR_W=5, ZERO_REG=1
    logic        reset = 1'b1;
    logic        iv = 1'b0;
    logic [4:0]  ird = '0, irs1 = '0, irs2 = '0;
    logic        ready;
    logic        wbv = 1'b0;
    logic [4:0]  wbrd = '0;
    logic        fl = 1'b0;
    logic [31:0] busy;
    logic [5:0]  cnt;
    logic        err;

    // Instance B: ADDR_W=3, ZERO_REG=0
    logic        b_reset = 1'b1;
    logic        b_iv = 1'b0;
    logic [2:0]  b_ird = '0, b_irs1 = '0, b_irs2 = '0;
    logic        b_ready;
    logic        b_wbv = 1'b0;
    logic [2:0]  b_wbrd = '0;
    logic        b_fl = 1'b0;
    logic [7:0]  b_busy;
    logic [3:0]  b_cnt;
    logic        b_err;

    reg_scoreboard #(.ADDR_W(5), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .issue_valid(iv), .issue_rd(ird), .issue_rs1(irs1), .issue_rs2(irs2),
        .issue_ready(ready),
        .wb_valid(wbv), .wb_rd(wbrd), .flush(fl),
        .busy(busy), .busy_count(cnt), .err(err)
    );

    reg_scoreboard #(.ADDR_W(3), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .reset(b_reset),
        .issue_valid(b_iv), .issue_rd(b_ird), .issue_rs1(b_irs1), .issue_rs2(b_irs2),
        .issue_ready(b_ready),
        .wb_valid(b_wbv), .wb_rd(b_wbrd), .flush(b_fl),
        .busy(b_busy), .busy_count(b_cnt), .err(b_err)
    );

    always #5 clk = ~clk;

    // Reference model for instance A: one pending flag per register.
    bit mb [32];
    bit me;

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) if (mb[i]) v = v | (32'd1 << i);
        return v;
    endfunction

    function automatic int model_count();
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(mb[i]);
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mb[i] = 1'b0;
    endtask

    // Async reset asserted between edges with traffic present; nothing may
    // take effect while held, and outputs drop immediately.
    task automatic reset_a();
        @(negedge clk);
        #2;
        iv = 1'b1; ird = 5'd6; irs1 = 5'd1; irs2 = 5'd2;
        wbv = 1'b1; wbrd = 5'd9; fl = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 32'h0);
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        check("rst_hold_busy", busy, 32'h0);
        check("rst_hold_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0; iv = 1'b0; wbv = 1'b0;
        model_clear();
        me = 1'b0;
    endtask

    task automatic step(input bit v, input int rd, input int rs1, input int rs2,
                        input bit wv, input int wr, input bit f);
        bit exp_ready;
        bit acc;
        @(negedge clk);
        iv = v; ird = rd[4:0]; irs1 = rs1[4:0]; irs2 = rs2[4:0];
        wbv = wv; wbrd = wr[4:0]; fl = f;
        #1;
        exp_ready = !(mb[rs1] || mb[rs2] || mb[rd]);
        check("ready", 32'(ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk); #1;
        if (f) begin
            model_clear();
        end else begin
            if (wv) begin
                if (!mb[wr] && wr != 0) me = 1'b1;
                mb[wr] = 1'b0;
            end
            if (acc && rd != 0) mb[rd] = 1'b1;
        end
        check("busy", busy, model_vec());
        check("count", 32'(cnt), 32'(model_count()));
        check("err", 32'(err), 32'(me));
    endtask

    task automatic idle_a();
        @(negedge clk);
        iv = 1'b0; wbv = 1'b0; fl = 1'b0;
    endtask

    initial begin
        int rd, rs1, rs2, wr;
        bit v, wv, f;
        int pend [$];

        me = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        reset_a();

        // Basic issue: RD=5, RS1=1, RS2=2
        step(1, 5, 1, 2, 0, 0, 0);
        check("issue5_busy", busy, 32'h0000_0020);
        check("issue5_count", 32'(cnt), 32'd1);
        step(0, 0, 1, 2, 0, 0, 0);
        check("rd0_ready", 32'(ready), 32'd1);

        // RAW hazard on 5 with same-cycle writeback: no bypass
        step(1, 7, 5, 2, 1, 5, 0);
        check("nobypass_busy", busy, 32'h0);
        step(1, 7, 5, 2, 0, 0, 0);
        check("after_wb_busy", busy, 32'h0000_0080);
        step(0, 0, 0, 0, 1, 7, 0);

        // Zero register
        step(1, 0, 0, 0, 0, 0, 0);
        check("zero_busy", busy, 32'h0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("zero_err", 32'(err), 32'd0);

        // Stray writeback sets sticky error; survives flush
        step(0, 0, 0, 0, 1, 7, 0);
        check("stray_err", 32'(err), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("err_flush", 32'(err), 32'd1);
        reset_a();

        // Issues then flush overriding same-cycle issue
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0, 0);
        check("pre_flush_count", 32'(cnt), 32'd3);
        step(1, 10, 0, 0, 1, 3, 1);
        check("flush_busy", busy, 32'h0);
        check("flush_count", 32'(cnt), 32'd0);
        check("flush_err", 32'(err), 32'd0);

        // Issue and writeback to different registers
        step(1, 12, 1, 1, 0, 0, 0);
        step(1, 13, 1, 1, 1, 12, 0);
        check("diff_busy", busy, 32'h0000_2000);

        // Issue and stray writeback on the same register: set wins, error
        step(1, 6, 0, 0, 1, 6, 0);
        check("same_busy", busy, 32'h0000_2040);
        check("same_err", 32'(err), 32'd1);

        // Randomized traffic, reset between chunks to keep ERR meaningful
        for (int chunk = 0; chunk < 4; chunk++) begin
            reset_a();
            for (int i = 0; i < 150; i++) begin
                rd  = int'($urandom_range(0, 7));
                rs1 = int'($urandom_range(0, 7));
                rs2 = int'($urandom_range(0, 7));
                v   = 1'($urandom_range(0, 1));
                wv  = ($urandom_range(0, 9) < 6);
                pend.delete();
                for (int r = 0; r < 32; r++) if (mb[r]) pend.push_back(r);
                if (pend.size() > 0 && $urandom_range(0, 19) != 0)
                    wr = pend[$urandom_range(0, pend.size() - 1)];
                else
                    wr = int'($urandom_range(0, 31));
                f = ($urandom_range(0, 24) == 0);
                step(v, rd, rs1, rs2, wv, wr, f);
            end
        end
        idle_a();

        // Instance B: 3-bit addresses, register 0 not hardwired
        @(negedge clk);
        b_reset = 1'b0;
        b_iv = 1'b1; b_ird = 3'd7; b_irs1 = 3'd1; b_irs2 = 3'd2;
        @(posedge clk); #1;
        check("b_issue7", 32'(b_busy), 32'h80);
        check("b_count7", 32'(b_cnt), 32'd1);
        @(negedge clk);
        b_iv = 1'b0;
        #2;
        b_reset = 1'b1;
        #1;
        check("b_async_rst", 32'(b_busy), 32'h0);
        @(negedge clk);
        b_reset = 1'b0;
        b_iv = 1'b1; b_ird = 3'd0; b_irs1 = 3'd1; b_irs2 = 3'd2;
        @(posedge clk); #1;
        check("b_issue0", 32'(b_busy), 32'h01);
        @(negedge clk);
        b_iv = 1'b0; b_wbv = 1'b1; b_wbrd = 3'd0;
        @(posedge clk); #1;
        check("b_wb0_busy", 32'(b_busy), 32'h0);
        check("b_wb0_err", 32'(b_err), 32'd0);
        @(negedge clk);
        b_wbrd = 3'd0;
        @(posedge clk); #1;
        check("b_stray0_err", 32'(b_err), 32'd1);
        @(negedge clk);
        b_wbv = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width; NREGS = 2**ADDR_W is derived, not overridable.
REQ-002 Parameter ZERO_REG, default 1; when 1, register 0 is never marked busy.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, asynchronous and active-high.
REQ-005 ISSUE_VALID  input  1  instruction presented for issue.
REQ-006 ISSUE_RD  input  ADDR_W  destination register of presented instruction.
REQ-007 ISSUE_RS1 / ISSUE_RS2  input  ADDR_W each  source registers of presented instruction.
REQ-008 ISSUE_READY  output  1  no hazard on RS1, RS2 or RD; issue accepted when ISSUE_VALID & ISSUE_READY.
REQ-009 WB_VALID  input  1  writeback completing this cycle.
REQ-010 WB_RD  input  ADDR_W  register being written back.
REQ-011 FLUSH  input  1  pipeline flush; clears all pending entries.
REQ-012 BUSY  output  NREGS  registered busy vector, bit i = register i has a pending write.
REQ-013 BUSY_COUNT  output  ADDR_W+1  population count of BUSY.
REQ-014 ERR  output  1  sticky: writeback to a non-busy register detected.

Function
REQ-015 ISSUE_READY SHALL be combinational from the current BUSY register only: !(BUSY[RS1] | BUSY[RS2] | BUSY[RD]); a same-cycle writeback SHALL NOT bypass into ISSUE_READY.
REQ-016 ISSUE_READY SHALL be independent of ISSUE_VALID.
REQ-017 Accepted issue SHALL set BUSY[ISSUE_RD] at the next edge, except when ISSUE_RD==0 and ZERO_REG==1.
REQ-018 WB_VALID SHALL clear BUSY[WB_RD] at the next edge (latency 1).
REQ-019 WB_VALID with BUSY[WB_RD]==0 SHALL set ERR at the next edge, except WB_RD==0 with ZERO_REG==1; BUSY SHALL be unchanged by that writeback.
REQ-020 Accepted issue and writeback to the same register in one cycle: set SHALL win, BUSY bit ends 1, ERR set per REQ-019.
REQ-021 Accepted issue and writeback to different registers in one cycle SHALL both take effect.
REQ-022 FLUSH SHALL clear all BUSY bits at the next edge, overriding same-cycle issue and writeback; ERR SHALL be unaffected by FLUSH, and the REQ-019 check SHALL be suppressed during FLUSH.
REQ-023 ERR SHALL remain 1 until RESET.
REQ-024 BUSY_COUNT SHALL be combinational from BUSY, range 0..NREGS (0..NREGS-1 when ZERO_REG==1).
REQ-025 With ZERO_REG==1, BUSY[0] SHALL be constant 0.

Reset
REQ-026 RESET high SHALL immediately force BUSY=0, BUSY_COUNT=0, ERR=0; ISSUE_READY SHALL consequently be 1.
REQ-027 RESET asserted mid-operation SHALL discard all pending entries; no issue or writeback SHALL take effect while RESET is high.
REQ-028 Deassertion SHALL be followed by normal operation from the first rising edge.

Structure
REQ-029 Shared package SHALL hold the default ADDR_W (5) and the zero-register index constant.
REQ-030 One sub-module, onehot_decoder (parameter ADDR_W, inputs EN and IN, output OUT of width 2**ADDR_W, OUT=0 when EN=0), SHALL be instantiated twice: set-mask from the issue path and clear-mask from the writeback path.

Verification
REQ-031 Reset then issue RD=5, RS1=1, RS2=2 -> next cycle BUSY=0x0000_0020, BUSY_COUNT=1, ISSUE_READY=1 for the same RS/RD=0.
REQ-032 BUSY[5]=1, present RS1=5 -> ISSUE_READY=0; WB_RD=5 same cycle -> ISSUE_READY still 0 that cycle, 1 the next cycle.
REQ-033 Issue RD=0 with ZERO_REG=1 -> BUSY stays 0; WB_RD=0 -> ERR stays 0.
REQ-034 BUSY=0, WB_VALID with WB_RD=7 -> ERR=1 next cycle; ERR stays 1 across FLUSH, clears only on RESET.
REQ-035 Issue RD=3, 4, 9 on successive cycles, then FLUSH with issue RD=10 in the same cycle -> BUSY=0, BUSY_COUNT=0 next cycle.
REQ-036 ADDR_W=3 build: issue RD=7 -> BUSY=8'h80; async RESET between clock edges -> BUSY=0 before the next edge.
